// File: rtl/branch_resolve_ctrl_if.sv
// Bundle between the execute stage, the shared branch comparator, fetch and
// the BHT on one side and branch_resolve_ctrl on the other.
//   slave  : branch_resolve_ctrl (consumes EX instr, drives comparator,
//            redirect/flush, BHT update and counters)
//   master : surrounding pipeline (EX stage, comparator, fetch, BHT)
// Parameter CNT_W sets the width of the performance counters.
interface branch_resolve_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_opnd_rdy;
  logic             ex_is_br;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic [2:0]       ex_funct3;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_imm;
  logic [31:0]      ex_rs1;
  logic [31:0]      ex_rs2;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;
  logic [2:0]       cmp_op;
  logic [31:0]      cmp_a;
  logic [31:0]      cmp_b;
  logic             cmp_br_en;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ack;
  logic             flush;
  logic             bht_upd_valid;
  logic [31:0]      bht_upd_pc;
  logic             bht_upd_taken;
  logic             err_illegal;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport slave (
    input  ex_valid, ex_opnd_rdy, ex_is_br, ex_is_jal, ex_is_jalr, ex_funct3,
           ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_taken, ex_pred_target,
           cmp_br_en, redirect_ack,
    output ex_ready, cmp_op, cmp_a, cmp_b, redirect_valid, redirect_pc, flush,
           bht_upd_valid, bht_upd_pc, bht_upd_taken, err_illegal, br_count,
           mispred_count
  );

  modport master (
    output ex_valid, ex_opnd_rdy, ex_is_br, ex_is_jal, ex_is_jalr, ex_funct3,
           ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_taken, ex_pred_target,
           cmp_br_en, redirect_ack,
    input  ex_ready, cmp_op, cmp_a, cmp_b, redirect_valid, redirect_pc, flush,
           bht_upd_valid, bht_upd_pc, bht_upd_taken, err_illegal, br_count,
           mispred_count
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution controller for the pipelined RV32I core.
// Drives the shared combinational comparator, resolves direction/target of
// BEQ..BGEU/JAL/JALR, checks against the fetch prediction, and on a mispredict
// issues a one-cycle flush plus a redirect held until fetch acknowledges it.
// Also emits BHT update pulses and branch/mispredict counters.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - branch_resolve_ctrl_if.slave (EX handshake, comparator, redirect,
//          flush, BHT update, err_illegal, counters)
// Parameter CNT_W must match the interface instance's CNT_W.
module branch_resolve_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_ctrl_if.slave  bus
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  logic             bht_upd_valid_q, bht_upd_valid_d;
  logic [31:0]      bht_upd_pc_q, bht_upd_pc_d;
  logic             bht_upd_taken_q, bht_upd_taken_d;
  logic             err_illegal_q, err_illegal_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

  logic        is_jalr, is_jal, is_br;
  logic        illegal, taken, mispred, fire;
  logic [31:0] jalr_sum, target, next_pc;

  // Comparator is combinational and shared; operands pass straight through.
  assign bus.cmp_op = bus.ex_funct3;
  assign bus.cmp_a  = bus.ex_rs1;
  assign bus.cmp_b  = bus.ex_rs2;

  assign bus.ex_ready       = (state_q == ST_IDLE);
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.bht_upd_valid  = bht_upd_valid_q;
  assign bus.bht_upd_pc     = bht_upd_pc_q;
  assign bus.bht_upd_taken  = bht_upd_taken_q;
  assign bus.err_illegal    = err_illegal_q;
  assign bus.br_count       = br_count_q;
  assign bus.mispred_count  = mispred_count_q;

  always_comb begin
    // Type decode with priority jalr > jal > br.
    is_jalr = bus.ex_is_jalr;
    is_jal  = bus.ex_is_jal & ~bus.ex_is_jalr;
    is_br   = bus.ex_is_br & ~bus.ex_is_jal & ~bus.ex_is_jalr;

    illegal  = is_br & ((bus.ex_funct3 == 3'b010) | (bus.ex_funct3 == 3'b011));
    taken    = is_br ? (bus.cmp_br_en & ~illegal) : 1'b1;
    jalr_sum = bus.ex_rs1 + bus.ex_imm;
    target   = is_jalr ? (jalr_sum & ~32'h1) : (bus.ex_pc + bus.ex_imm);
    next_pc  = taken ? target : (bus.ex_pc + 32'd4);
    mispred  = (taken != bus.ex_pred_taken) |
               (taken & (target != bus.ex_pred_target));
    fire     = (state_q == ST_IDLE) & bus.ex_valid & bus.ex_opnd_rdy &
               (is_br | is_jal | is_jalr);

    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    bht_upd_valid_d  = 1'b0;
    bht_upd_pc_d     = bht_upd_pc_q;
    bht_upd_taken_d  = bht_upd_taken_q;
    err_illegal_d    = err_illegal_q;
    br_count_d       = br_count_q;
    mispred_count_d  = mispred_count_q;

    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          br_count_d = br_count_q + CNT_W'(1);
          if (is_br) begin
            bht_upd_valid_d = 1'b1;
            bht_upd_pc_d    = bus.ex_pc;
            bht_upd_taken_d = taken;
          end
          if (illegal) begin
            err_illegal_d = 1'b1;
          end
          if (mispred) begin
            mispred_count_d  = mispred_count_q + CNT_W'(1);
            flush_d          = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = next_pc;
            state_d          = ST_REDIRECT;
          end
        end
      end
      ST_REDIRECT: begin
        // redirect_valid is already high in this state, so an ack in the
        // first REDIRECT cycle yields a single-cycle redirect pulse.
        if (bus.redirect_ack) begin
          redirect_valid_d = 1'b0;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      bht_upd_valid_q  <= 1'b0;
      bht_upd_pc_q     <= '0;
      bht_upd_taken_q  <= 1'b0;
      err_illegal_q    <= 1'b0;
      br_count_q       <= '0;
      mispred_count_q  <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      bht_upd_valid_q  <= bht_upd_valid_d;
      bht_upd_pc_q     <= bht_upd_pc_d;
      bht_upd_taken_q  <= bht_upd_taken_d;
      err_illegal_q    <= err_illegal_d;
      br_count_q       <= br_count_d;
      mispred_count_q  <= mispred_count_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl.
module tb_branch_resolve_ctrl;

  logic clk;
  logic rst;
  int unsigned n_total;
  int unsigned n_bad;

  branch_resolve_ctrl_if #(.CNT_W(32)) bus ();

  branch_resolve_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared comparator. Undefined codes report true so the
  // controller's own masking of illegal funct3 is what keeps them not-taken.
  always_comb begin
    case (bus.cmp_op)
      3'b000:  bus.cmp_br_en = (bus.cmp_a == bus.cmp_b);
      3'b001:  bus.cmp_br_en = (bus.cmp_a != bus.cmp_b);
      3'b100:  bus.cmp_br_en = ($signed(bus.cmp_a) <  $signed(bus.cmp_b));
      3'b101:  bus.cmp_br_en = ($signed(bus.cmp_a) >= $signed(bus.cmp_b));
      3'b110:  bus.cmp_br_en = (bus.cmp_a <  bus.cmp_b);
      3'b111:  bus.cmp_br_en = (bus.cmp_a >= bus.cmp_b);
      default: bus.cmp_br_en = 1'b1;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one instruction for a single cycle; returns #1 after the edge
  // that captured it, so registered results of T+1 are visible.
  task automatic issue(input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic pt,
                       input logic [31:0] ptgt);
    bus.ex_valid       = 1'b1;
    bus.ex_opnd_rdy    = 1'b1;
    bus.ex_is_br       = br;
    bus.ex_is_jal      = jal;
    bus.ex_is_jalr     = jalr;
    bus.ex_funct3      = f3;
    bus.ex_pc          = pc;
    bus.ex_imm         = imm;
    bus.ex_rs1         = rs1;
    bus.ex_rs2         = rs2;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptgt;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_opnd_rdy = 1'b0;
    bus.ex_is_br = 1'b0; bus.ex_is_jal = 1'b0; bus.ex_is_jalr = 1'b0;
    bus.ex_funct3 = '0; bus.ex_pc = '0; bus.ex_imm = '0;
    bus.ex_rs1 = '0; bus.ex_rs2 = '0;
    bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
    bus.redirect_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("rst_redirect_pc",    bus.redirect_pc, 32'd0);
    check("rst_flush",          32'(bus.flush), 32'd0);
    check("rst_bht_valid",      32'(bus.bht_upd_valid), 32'd0);
    check("rst_err",            32'(bus.err_illegal), 32'd0);
    check("rst_br_count",       bus.br_count, 32'd0);
    check("rst_mispred_count",  bus.mispred_count, 32'd0);
    check("rst_ex_ready",       32'(bus.ex_ready), 32'd1);

    // Comparator pass-through
    bus.ex_funct3 = 3'b101; bus.ex_rs1 = 32'hDEAD_0001; bus.ex_rs2 = 32'h0000_BEEF;
    #1;
    check("cmp_op", 32'(bus.cmp_op), 32'd5);
    check("cmp_a",  bus.cmp_a, 32'hDEAD_0001);
    check("cmp_b",  bus.cmp_b, 32'h0000_BEEF);

    // BEQ equal operands, predicted not taken -> redirect to 0x120
    issue(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0);
    check("beq_redirect_valid", 32'(bus.redirect_valid), 32'd1);
    check("beq_redirect_pc",    bus.redirect_pc, 32'h120);
    check("beq_flush",          32'(bus.flush), 32'd1);
    check("beq_mispred",        bus.mispred_count, 32'd1);
    check("beq_br_count",       bus.br_count, 32'd1);
    check("beq_bht_valid",      32'(bus.bht_upd_valid), 32'd1);
    check("beq_bht_pc",         bus.bht_upd_pc, 32'h100);
    check("beq_bht_taken",      32'(bus.bht_upd_taken), 32'd1);
    check("beq_ex_ready",       32'(bus.ex_ready), 32'd0);
    // Ack in the first redirect cycle -> single-cycle pulse
    bus.redirect_ack = 1'b1;
    @(posedge clk); #1;
    bus.redirect_ack = 1'b0;
    check("beq_ack_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("beq_ack_flush",          32'(bus.flush), 32'd0);
    check("beq_ack_ex_ready",       32'(bus.ex_ready), 32'd1);
    check("beq_ack_bht_valid",      32'(bus.bht_upd_valid), 32'd0);

    // BLT -1 < 1, predicted taken to pc+imm -> correct
    issue(1'b1, 1'b0, 1'b0, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h240);
    check("blt_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("blt_bht_taken",      32'(bus.bht_upd_taken), 32'd1);
    check("blt_br_count",       bus.br_count, 32'd2);
    // BLTU back to back: 0xFFFFFFFF < 1 unsigned is false, predicted not taken
    issue(1'b1, 1'b0, 1'b0, 3'b110, 32'h204, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
    check("bltu_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("bltu_bht_valid",      32'(bus.bht_upd_valid), 32'd1);
    check("bltu_bht_taken",      32'(bus.bht_upd_taken), 32'd0);
    check("bltu_bht_pc",         bus.bht_upd_pc, 32'h204);
    check("bltu_br_count",       bus.br_count, 32'd3);
    check("bltu_mispred",        bus.mispred_count, 32'd1);

    // JALR rs1=0x203 -> target 0x202 (bit 0 cleared); correct prediction
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h300, 32'h0, 32'h203, 32'h0, 1'b1, 32'h202);
    check("jalr_ok_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("jalr_ok_bht_valid",      32'(bus.bht_upd_valid), 32'd0);
    check("jalr_ok_br_count",       bus.br_count, 32'd4);

    // JALR wrongly predicted target 0 -> redirect 0x202, ack held low 3 cycles
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h300, 32'h0, 32'h203, 32'h0, 1'b1, 32'h0);
    check("jalr_bad_redirect_pc", bus.redirect_pc, 32'h202);
    check("jalr_bad_mispred",     bus.mispred_count, 32'd2);
    // Offer another branch while held; it must not be accepted
    bus.ex_valid = 1'b1; bus.ex_is_jalr = 1'b0; bus.ex_is_br = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_redirect_valid", 32'(bus.redirect_valid), 32'd1);
      check("hold_redirect_pc",    bus.redirect_pc, 32'h202);
      check("hold_ex_ready",       32'(bus.ex_ready), 32'd0);
      check("hold_flush",          32'(bus.flush), 32'd0);
    end
    bus.ex_valid = 1'b0;
    bus.redirect_ack = 1'b1;
    @(posedge clk); #1;
    bus.redirect_ack = 1'b0;
    check("hold_ack_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("hold_ack_ex_ready",       32'(bus.ex_ready), 32'd1);
    check("hold_br_count",           bus.br_count, 32'd5);

    // JAL with is_br also set: jal wins; target 0x400-8 = 0x3F8
    issue(1'b1, 1'b1, 1'b0, 3'b001, 32'h400, 32'hFFFF_FFF8, 32'd7, 32'd7, 1'b1, 32'h3F8);
    check("jal_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("jal_bht_valid",      32'(bus.bht_upd_valid), 32'd0);
    check("jal_br_count",       bus.br_count, 32'd6);

    // ex_valid with no type bit: no fire
    issue(1'b0, 1'b0, 1'b0, 3'b000, 32'h500, 32'h10, 32'd0, 32'd1, 1'b1, 32'h0);
    check("notype_br_count",   bus.br_count, 32'd6);
    check("notype_redirect",   32'(bus.redirect_valid), 32'd0);
    // Operands not ready: no fire even though it would mispredict
    bus.ex_valid = 1'b1; bus.ex_opnd_rdy = 1'b0; bus.ex_is_br = 1'b1;
    bus.ex_funct3 = 3'b000; bus.ex_rs1 = 32'd3; bus.ex_rs2 = 32'd3;
    bus.ex_pred_taken = 1'b0;
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    check("stall_br_count", bus.br_count, 32'd6);
    check("stall_redirect", 32'(bus.redirect_valid), 32'd0);

    // Illegal funct3 010: not taken, sticky error
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h600, 32'h80, 32'd1, 32'd2, 1'b0, 32'h0);
    check("ill_err",            32'(bus.err_illegal), 32'd1);
    check("ill_bht_taken",      32'(bus.bht_upd_taken), 32'd0);
    check("ill_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("ill_br_count",       bus.br_count, 32'd7);
    @(posedge clk); #1;
    check("ill_err_sticky",     32'(bus.err_illegal), 32'd1);

    // BNE taken, predicted not taken -> redirect 0x700+0x10; reset mid-REDIRECT
    issue(1'b1, 1'b0, 1'b0, 3'b001, 32'h700, 32'h10, 32'd1, 32'd2, 1'b0, 32'h0);
    check("bne_redirect_pc", bus.redirect_pc, 32'h710);
    check("bne_mispred",     bus.mispred_count, 32'd3);
    check("bne_br_count",    bus.br_count, 32'd8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("rstmid_redirect_pc",    bus.redirect_pc, 32'd0);
    check("rstmid_flush",          32'(bus.flush), 32'd0);
    check("rstmid_bht_valid",      32'(bus.bht_upd_valid), 32'd0);
    check("rstmid_bht_pc",         bus.bht_upd_pc, 32'd0);
    check("rstmid_err",            32'(bus.err_illegal), 32'd0);
    check("rstmid_br_count",       bus.br_count, 32'd0);
    check("rstmid_mispred",        bus.mispred_count, 32'd0);
    check("rstmid_ex_ready",       32'(bus.ex_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
